// File: rtl/serial_adder.sv
// serial_adder: bit-serial ripple adder built around one fulladder cell.
// Operands are captured on an accepted start, then one bit pair per clock
// (LSB first) goes through the fulladder while the carry is held in a flop.
// Optional build macro SERIAL_ADDER_OVF_EN adds a registered signed-overflow
// output port ovf.
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_IDLE | waiting for start; sum/cout hold the last result
// S_RUN  | one operand bit pair per clock through the fulladder cell

module fulladder (
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic sum,
  output logic c_out
);

  assign sum   = a ^ b ^ c_in;
  assign c_out = (a & b) | (c_in & (a ^ b));

endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  , output logic           ovf
`endif
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] ps_q, ps_d;
  logic             c_q, c_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             done_q, done_d;

  logic fa_sum;
  logic fa_cout;

  fulladder u_fa (
    .a     (sa_q[0]),
    .b     (sb_q[0]),
    .c_in  (c_q),
    .sum   (fa_sum),
    .c_out (fa_cout)
  );

`ifdef SERIAL_ADDER_OVF_EN
  logic ovf_q, ovf_d;

  // Signed overflow: carry into the MSB (still in c_q on the last bit) vs carry out.
  always_comb begin
    ovf_d = ovf_q;
    if (state_q == S_RUN && cnt_q == LAST_BIT) begin
      ovf_d = c_q ^ fa_cout;
    end
  end

  // Overflow flag register, updated only at completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`endif

  // Next-state and datapath sequencing; start is only looked at in S_IDLE.
  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    ps_d    = ps_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          sa_d    = a;
          sb_d    = b;
          c_d     = cin;
          cnt_d   = '0;
          ps_d    = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        ps_d  = {fa_sum, ps_q[WIDTH-1:1]};
        c_d   = fa_cout;
        sa_d  = sa_q >> 1;
        sb_d  = sb_q >> 1;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST_BIT) begin
          sum_d   = {fa_sum, ps_q[WIDTH-1:1]};
          cout_d  = fa_cout;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, datapath and result registers; reset aborts any addition in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      ps_q    <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      ps_q    <= ps_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q == S_RUN);
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule
